// File: rtl/key_cmd_scheduler.sv
// Two-player keyboard command scheduler: per-player capture FSM and FIFO,
// round-robin arbitration with per-player cooldown onto one valid/ready channel.
module key_cmd_scheduler #(
    parameter int FIFO_DEPTH      = 4,
    parameter int COOLDOWN_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       kb0_ready,
    input  logic [2:0] kb0_data,
    output logic       kb0_read_fin,
    input  logic       kb1_ready,
    input  logic [2:0] kb1_data,
    output logic       kb1_read_fin,
    output logic       cmd_valid,
    output logic       cmd_player,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    output logic [1:0] drop_flag,
    input  logic       drop_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CD_W  = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACK      = 2'd1;
    localparam logic [1:0] ST_WAIT_CLR = 2'd2;

    logic [1:0] kb_ready;
    logic [2:0] kb_data [2];
    logic [1:0] read_fin;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] drop_set;
    logic [1:0] eligible;
    logic [2:0] head_code [2];

    logic       accept;
    logic       load_slot;
    logic       grant_any;
    logic       grant_sel;
    logic       rr_ptr;

    assign kb_ready   = {kb1_ready, kb0_ready};
    assign kb_data[0] = kb0_data;
    assign kb_data[1] = kb1_data;

    assign kb0_read_fin = read_fin[0];
    assign kb1_read_fin = read_fin[1];

    assign accept    = cmd_valid & cmd_ready;
    assign load_slot = ~cmd_valid | cmd_ready;

    for (genvar p = 0; p < 2; p++) begin : g_player
        logic [1:0]       state;
        logic [2:0]       cap_code;
        logic [2:0]       mem [FIFO_DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] count;
        logic [CD_W-1:0]  cd;
        logic             code_legal;
        logic             fifo_full;
        logic             cd_block;

        assign code_legal = (cap_code <= 3'd5);
        assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        assign read_fin[p] = (state == ST_ACK);

        // A full FIFO still accepts a push when the arbiter pops it in the same cycle.
        assign push[p]     = (state == ST_ACK) && code_legal && (!fifo_full || pop[p]);
        assign drop_set[p] = (state == ST_ACK) && !push[p];
        assign head_code[p] = mem[rd_ptr];

        // The player being accepted this cycle is not yet cooling down, so mask it explicitly.
        assign cd_block    = (COOLDOWN_CYCLES != 0) && accept && (cmd_player == 1'(p));
        assign eligible[p] = (count != '0) && (cd == '0) && !cd_block;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:     if (kb_ready[p]) state <= ST_ACK;
                    ST_ACK:      state <= ST_WAIT_CLR;
                    ST_WAIT_CLR: if (!kb_ready[p]) state <= ST_IDLE;
                    default:     state <= ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clock) begin
            if (state == ST_IDLE && kb_ready[p]) cap_code <= kb_data[p];
        end

        always_ff @(posedge clock) begin
            if (push[p]) mem[wr_ptr] <= cap_code;
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[p]) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop[p])  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push[p], pop[p]})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cd <= '0;
            end else if (accept && cmd_player == 1'(p)) begin
                cd <= CD_W'(COOLDOWN_CYCLES);
            end else if (cd != '0) begin
                cd <= cd - CD_W'(1);
            end
        end
    end

    // rr_ptr holds the player preferred on a tie; on an accept cycle the tie goes to the other player.
    always_comb begin
        grant_any = 1'b0;
        grant_sel = 1'b0;
        if (load_slot) begin
            grant_any = |eligible;
            if (&eligible) begin
                grant_sel = accept ? ~cmd_player : rr_ptr;
            end else begin
                grant_sel = eligible[1];
            end
        end
    end

    assign pop = grant_any ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid  <= 1'b0;
            cmd_player <= 1'b0;
            cmd_code   <= 3'd0;
        end else if (load_slot) begin
            cmd_valid <= grant_any;
            if (grant_any) begin
                cmd_player <= grant_sel;
                cmd_code   <= head_code[grant_sel];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~cmd_player;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_flag <= 2'b00;
        end else begin
            drop_flag <= (drop_flag & {2{~drop_clr}}) | drop_set;
        end
    end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Bench for key_cmd_scheduler: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_key_cmd_scheduler;

    localparam int DEPTH  = 4;
    localparam int CD_CYC = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       kb0_ready = 1'b0;
    logic [2:0] kb0_data = 3'd0;
    logic       kb1_ready = 1'b0;
    logic [2:0] kb1_data = 3'd0;
    logic       cmd_ready = 1'b0;
    logic       drop_clr = 1'b0;

    logic       cd_rf0, cd_rf1, cd_valid, cd_player;
    logic [2:0] cd_code;
    logic [1:0] cd_drop;
    logic       nc_rf0, nc_rf1, nc_valid, nc_player;
    logic [2:0] nc_code;
    logic [1:0] nc_drop;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    key_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .COOLDOWN_CYCLES(CD_CYC)) u_cd (
        .clock(clock), .reset_n(reset_n),
        .kb0_ready(kb0_ready), .kb0_data(kb0_data), .kb0_read_fin(cd_rf0),
        .kb1_ready(kb1_ready), .kb1_data(kb1_data), .kb1_read_fin(cd_rf1),
        .cmd_valid(cd_valid), .cmd_player(cd_player), .cmd_code(cd_code),
        .cmd_ready(cmd_ready), .drop_flag(cd_drop), .drop_clr(drop_clr)
    );

    key_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .COOLDOWN_CYCLES(0)) u_nc (
        .clock(clock), .reset_n(reset_n),
        .kb0_ready(kb0_ready), .kb0_data(kb0_data), .kb0_read_fin(nc_rf0),
        .kb1_ready(kb1_ready), .kb1_data(kb1_data), .kb1_read_fin(nc_rf1),
        .cmd_valid(nc_valid), .cmd_player(nc_player), .cmd_code(nc_code),
        .cmd_ready(cmd_ready), .drop_flag(nc_drop), .drop_clr(drop_clr)
    );

    typedef struct {
        logic       k0r;
        logic [2:0] k0d;
        logic       k1r;
        logic [2:0] k1d;
        logic       cr;
        logic       clr;
        logic       rf0;
        logic       rf1;
        logic       v;
        logic       p;
        logic [2:0] c;
        logic [1:0] dr;
    } vec_t;

    vec_t vt [23];

    function automatic vec_t mk(input logic k0r, input logic [2:0] k0d, input logic k1r,
                                input logic [2:0] k1d, input logic cr, input logic clr,
                                input logic rf0, input logic rf1, input logic v, input logic p,
                                input logic [2:0] c, input logic [1:0] dr);
        vec_t r;
        r.k0r = k0r; r.k0d = k0d; r.k1r = k1r; r.k1d = k1d; r.cr = cr; r.clr = clr;
        r.rf0 = rf0; r.rf1 = rf1; r.v = v; r.p = p; r.c = c; r.dr = dr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        kb0_ready = 1'b0; kb0_data = 3'd0;
        kb1_ready = 1'b0; kb1_data = 3'd0;
        cmd_ready = 1'b0; drop_clr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic push_evt1(input logic [2:0] c);
        kb1_ready = 1'b1; kb1_data = c;
        step();
        kb1_ready = 1'b0;
        step();
        step();
    endtask

    task automatic push_evt0(input logic [2:0] c);
        kb0_ready = 1'b1; kb0_data = c;
        step();
        kb0_ready = 1'b0;
        step();
        step();
    endtask

    // Reference model: per-player queues, capture phase, cooldown counts.
    int m_ph [2];
    int m_cap [2];
    int m_cd [2];
    int m_rr;
    int m_valid, m_player, m_code;
    bit m_drop [2];
    int mq0 [$];
    int mq1 [$];

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_ph[p] = 0; m_cap[p] = 0; m_cd[p] = 0; m_drop[p] = 1'b0;
        end
        m_rr = 0; m_valid = 0; m_player = 0; m_code = 0;
        mq0.delete();
        mq1.delete();
    endtask

    task automatic model_step();
        int sz [2];
        bit el [2];
        bit rdy [2];
        int dat [2];
        bit setf [2];
        int g;
        bit acc, slot;
        int accp;
        sz[0] = mq0.size(); sz[1] = mq1.size();
        rdy[0] = kb0_ready; rdy[1] = kb1_ready;
        dat[0] = int'(kb0_data); dat[1] = int'(kb1_data);
        acc  = (m_valid != 0) && cmd_ready;
        slot = (m_valid == 0) || cmd_ready;
        accp = m_player;
        for (int p = 0; p < 2; p++)
            el[p] = sz[p] > 0 && m_cd[p] == 0 && !(acc && accp == p && CD_CYC > 0);
        g = -1;
        if (slot) begin
            if (el[0] && el[1]) g = acc ? 1 - accp : m_rr;
            else if (el[0]) g = 0;
            else if (el[1]) g = 1;
            m_valid = (g >= 0) ? 1 : 0;
            if (g == 0) begin m_player = 0; m_code = mq0.pop_front(); end
            if (g == 1) begin m_player = 1; m_code = mq1.pop_front(); end
        end
        for (int p = 0; p < 2; p++) begin
            setf[p] = 1'b0;
            if (m_ph[p] == 1) begin
                if (m_cap[p] <= 5 && (sz[p] < DEPTH || g == p)) begin
                    if (p == 0) mq0.push_back(m_cap[p]);
                    else        mq1.push_back(m_cap[p]);
                end else begin
                    setf[p] = 1'b1;
                end
            end
            if (m_ph[p] == 0) begin
                if (rdy[p]) begin m_cap[p] = dat[p]; m_ph[p] = 1; end
            end else if (m_ph[p] == 1) begin
                m_ph[p] = 2;
            end else if (!rdy[p]) begin
                m_ph[p] = 0;
            end
            if (acc && accp == p) m_cd[p] = CD_CYC;
            else if (m_cd[p] > 0) m_cd[p] = m_cd[p] - 1;
            m_drop[p] = setf[p] ? 1'b1 : (drop_clr ? 1'b0 : m_drop[p]);
        end
        if (acc) m_rr = 1 - accp;
    endtask

    task automatic model_compare();
        chk("rnd_valid", 32'(cd_valid), 32'(m_valid));
        if (m_valid != 0) begin
            chk("rnd_player", 32'(cd_player), 32'(m_player));
            chk("rnd_code", 32'(cd_code), 32'(m_code));
        end
        chk("rnd_rf0", 32'(cd_rf0), 32'(m_ph[0] == 1));
        chk("rnd_rf1", 32'(cd_rf1), 32'(m_ph[1] == 1));
        chk("rnd_drop", 32'(cd_drop), 32'({m_drop[1], m_drop[0]}));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int got [$];
        int thr;

        vt[0]  = mk(1, 3'd3, 0, 3'd0, 1, 0,  1, 0, 0, 0, 3'd0, 2'd0);
        vt[1]  = mk(1, 3'd3, 0, 3'd0, 1, 0,  0, 0, 0, 0, 3'd0, 2'd0);
        vt[2]  = mk(0, 3'd0, 0, 3'd0, 1, 0,  0, 0, 1, 0, 3'd3, 2'd0);
        vt[3]  = mk(0, 3'd0, 0, 3'd0, 1, 0,  0, 0, 0, 0, 3'd0, 2'd0);
        vt[4]  = mk(1, 3'd7, 0, 3'd0, 1, 0,  1, 0, 0, 0, 3'd0, 2'd0);
        vt[5]  = mk(0, 3'd0, 0, 3'd0, 1, 0,  0, 0, 0, 0, 3'd0, 2'd1);
        vt[6]  = mk(0, 3'd0, 0, 3'd0, 1, 1,  0, 0, 0, 0, 3'd0, 2'd0);
        vt[7]  = mk(0, 3'd0, 1, 3'd6, 1, 0,  0, 1, 0, 0, 3'd0, 2'd0);
        vt[8]  = mk(0, 3'd0, 0, 3'd0, 1, 1,  0, 0, 0, 0, 3'd0, 2'd2);
        vt[9]  = mk(0, 3'd0, 0, 3'd0, 1, 1,  0, 0, 0, 0, 3'd0, 2'd0);
        vt[10] = mk(0, 3'd0, 1, 3'd5, 1, 0,  0, 1, 0, 0, 3'd0, 2'd0);
        vt[11] = mk(0, 3'd0, 0, 3'd0, 1, 0,  0, 0, 0, 0, 3'd0, 2'd0);
        vt[12] = mk(0, 3'd0, 0, 3'd0, 1, 0,  0, 0, 1, 1, 3'd5, 2'd0);
        vt[13] = mk(0, 3'd0, 0, 3'd0, 1, 0,  0, 0, 0, 0, 3'd0, 2'd0);
        vt[14] = mk(1, 3'd2, 0, 3'd0, 1, 0,  1, 0, 0, 0, 3'd0, 2'd0);
        vt[15] = mk(1, 3'd2, 0, 3'd0, 1, 0,  0, 0, 0, 0, 3'd0, 2'd0);
        vt[16] = mk(1, 3'd2, 0, 3'd0, 1, 0,  0, 0, 0, 0, 3'd0, 2'd0);
        vt[17] = mk(1, 3'd2, 0, 3'd0, 1, 0,  0, 0, 0, 0, 3'd0, 2'd0);
        vt[18] = mk(0, 3'd0, 0, 3'd0, 1, 0,  0, 0, 0, 0, 3'd0, 2'd0);
        vt[19] = mk(0, 3'd0, 0, 3'd0, 1, 0,  0, 0, 0, 0, 3'd0, 2'd0);
        vt[20] = mk(0, 3'd0, 0, 3'd0, 1, 0,  0, 0, 1, 0, 3'd2, 2'd0);
        vt[21] = mk(0, 3'd0, 0, 3'd0, 1, 0,  0, 0, 0, 0, 3'd0, 2'd0);
        vt[22] = mk(0, 3'd0, 0, 3'd0, 1, 0,  0, 0, 0, 0, 3'd0, 2'd0);

        // Reset state
        do_reset();
        chk("rst_valid", 32'(cd_valid), 32'(0));
        chk("rst_player", 32'(cd_player), 32'(0));
        chk("rst_code", 32'(cd_code), 32'(0));
        chk("rst_rf", 32'({cd_rf1, cd_rf0}), 32'(0));
        chk("rst_drop", 32'(cd_drop), 32'(0));

        // Vector table: latency, illegal code, set-vs-clear, held ready, cooldown boundary
        for (int k = 0; k < 23; k++) begin
            kb0_ready = vt[k].k0r; kb0_data = vt[k].k0d;
            kb1_ready = vt[k].k1r; kb1_data = vt[k].k1d;
            cmd_ready = vt[k].cr;  drop_clr = vt[k].clr;
            step();
            chk($sformatf("vec%0d_rf0", k), 32'(cd_rf0), 32'(vt[k].rf0));
            chk($sformatf("vec%0d_rf1", k), 32'(cd_rf1), 32'(vt[k].rf1));
            chk($sformatf("vec%0d_valid", k), 32'(cd_valid), 32'(vt[k].v));
            chk($sformatf("vec%0d_drop", k), 32'(cd_drop), 32'(vt[k].dr));
            if (vt[k].v) begin
                chk($sformatf("vec%0d_player", k), 32'(cd_player), 32'(vt[k].p));
                chk($sformatf("vec%0d_code", k), 32'(cd_code), 32'(vt[k].c));
            end
        end

        // Simultaneous events with cooldown off: p0, then p1, then a lone p0
        do_reset();
        cmd_ready = 1'b1;
        kb0_ready = 1'b1; kb0_data = 3'd1; kb1_ready = 1'b1; kb1_data = 3'd4;
        step();
        chk("rr_rf_both", 32'({nc_rf1, nc_rf0}), 32'(3));
        kb0_ready = 1'b0; kb1_ready = 1'b0;
        step();
        chk("rr_wait", 32'(nc_valid), 32'(0));
        step();
        chk("rr_g1", 32'({nc_valid, nc_player, nc_code}), 32'({1'b1, 1'b0, 3'd1}));
        step();
        chk("rr_g2", 32'({nc_valid, nc_player, nc_code}), 32'({1'b1, 1'b1, 3'd4}));
        step();
        chk("rr_idle", 32'(nc_valid), 32'(0));
        push_evt0(3'd0);
        chk("rr_g3", 32'({nc_valid, nc_player, nc_code}), 32'({1'b1, 1'b0, 3'd0}));
        // Back-to-back same player when cooldown is off
        cmd_ready = 1'b0;
        step();
        push_evt0(3'd2);
        push_evt0(3'd3);
        chk("b2b_hold", 32'({nc_valid, nc_player, nc_code}), 32'({1'b1, 1'b0, 3'd0}));
        cmd_ready = 1'b1;
        step();
        chk("b2b_g1", 32'({nc_valid, nc_player, nc_code}), 32'({1'b1, 1'b0, 3'd2}));
        step();
        chk("b2b_g2", 32'({nc_valid, nc_player, nc_code}), 32'({1'b1, 1'b0, 3'd3}));

        // Backpressure: 5 events fit (register + FIFO), the 6th is dropped
        do_reset();
        for (int i = 0; i < 5; i++) push_evt1(3'(i));
        chk("bp_nodrop", 32'(cd_drop), 32'(0));
        chk("bp_head", 32'({cd_valid, cd_player, cd_code}), 32'({1'b1, 1'b1, 3'd0}));
        push_evt1(3'd5);
        chk("bp_drop", 32'(cd_drop), 32'(2));
        cmd_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (cd_valid) begin
                got.push_back(int'(cd_code));
                chk("bp_player", 32'(cd_player), 32'(1));
            end
            step();
        end
        chk("bp_count", 32'(got.size()), 32'(5));
        for (int i = 0; i < 5; i++)
            if (i < got.size()) chk($sformatf("bp_order%0d", i), 32'(got[i]), 32'(i));

        // Asynchronous reset mid-ACK with a command pending
        do_reset();
        push_evt1(3'd4);
        chk("ar_pending", 32'(cd_valid), 32'(1));
        kb0_ready = 1'b1; kb0_data = 3'd1;
        step();
        chk("ar_ack", 32'(cd_rf0), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(cd_valid), 32'(0));
        chk("ar_rf0", 32'(cd_rf0), 32'(0));
        chk("ar_out", 32'({cd_player, cd_code, cd_drop}), 32'(0));
        chk("ar_nc_valid", 32'(nc_valid), 32'(0));
        kb0_ready = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cmd_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            chk($sformatf("ar_stale%0d", n), 32'(cd_valid), 32'(0));
        end

        // Randomized run against the reference model
        do_reset();
        model_reset();
        thr = 50;
        for (int n = 0; n < 3000; n++) begin
            model_compare();
            if (n % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0:       thr = 10;
                    1:       thr = 50;
                    default: thr = 95;
                endcase
            end
            kb0_ready = ($urandom_range(0, 99) < 40);
            kb0_data  = 3'($urandom_range(0, 7));
            kb1_ready = ($urandom_range(0, 99) < 40);
            kb1_data  = 3'($urandom_range(0, 7));
            cmd_ready = ($urandom_range(0, 99) < thr);
            drop_clr  = ($urandom_range(0, 99) < 3);
            model_step();
            step();
        end
        model_compare();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
